// File: rtl/pipeline_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_fetch_ctrl
// Fetch sequencer for the pipeline IF stage. It drives the PC register
// enable/select, runs the instruction-memory req/ack handshake and owns the
// IF/ID pipeline register. It copes with variable-latency imem, ID
// back-pressure and EX redirects, including discarding a wrong-path response
// that is still outstanding when a redirect arrives.
//
// Parameters
//   NOP_INST  instruction placed in IF/ID on reset or flush
//   MAX_WAIT  unanswered request cycles before imem_err is raised (>= 2)
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   pc_if               current PC (IF-stage PC register output)
//   redirect_valid      EX taken branch/jump, one-cycle pulse
//   redirect_target     redirect destination
//   stall_id            ID cannot accept a new instruction this cycle
//   imem_req/imem_addr  fetch request (combinational from state) and address
//   imem_ack/imem_rdata one-cycle response pulse and fetched instruction
//   pc_en/pc_sel        PC register enable / select (0 = PC+4, 1 = pc_target)
//   pc_target           PC load value on redirect
//   ifid_valid/pc/inst  IF/ID register contents
//   imem_err            sticky fetch-timeout flag
// ---------------------------------------------------------------------------
module pipeline_fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall_id,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        pc_en,
  output logic        pc_sel,
  output logic [31:0] pc_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        imem_err
);

  localparam int unsigned      CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
  // The error flag rises on the cycle whose increment brings the count to MAX_WAIT-1.
  localparam logic [CNT_W-1:0] WAIT_ERR = CNT_W'(MAX_WAIT - 2);

  // FETCH: live request at pc_if; HOLD: buffer full, no request;
  // DROP: wrong-path request still outstanding at req_addr_q.
  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_e;

  state_e           state_q;
  logic [31:0]      req_addr_q;
  logic [31:0]      buf_pc_q;
  logic [31:0]      buf_inst_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             ifid_valid_q;
  logic [31:0]      ifid_pc_q;
  logic [31:0]      ifid_inst_q;
  logic             imem_err_q;

  logic             req_c;

  // Handshake and PC control, combinational from state and inputs.
  always_comb begin
    req_c     = 1'b0;
    imem_addr = pc_if;
    pc_en     = 1'b0;
    pc_sel    = 1'b0;
    pc_target = redirect_target;
    if (!rst) begin
      req_c = (state_q != S_HOLD);
      if (state_q == S_DROP) begin
        imem_addr = req_addr_q;
      end
      if (redirect_valid) begin
        pc_en  = 1'b1;
        pc_sel = 1'b1;
      end else if ((state_q == S_FETCH) && imem_ack) begin
        // A live response always advances the PC, even when it lands in the buffer.
        pc_en = 1'b1;
      end
    end
  end

  assign imem_req = req_c;

  // State, IF/ID, skid buffer, timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      req_addr_q   <= '0;
      buf_pc_q     <= '0;
      buf_inst_q   <= '0;
      wait_cnt_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP_INST;
      imem_err_q   <= 1'b0;
    end else begin
      // Timeout tracking runs only while a request is on the bus.
      if (req_c) begin
        if (imem_ack) begin
          wait_cnt_q <= '0;
        end else begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
          if (wait_cnt_q >= WAIT_ERR) begin
            imem_err_q <= 1'b1;
          end
        end
      end

      // Address of the live request; frozen once it goes stale in DROP.
      if (state_q == S_FETCH) begin
        req_addr_q <= pc_if;
      end

      if (redirect_valid) begin
        // Flush IF/ID and the buffer; an unanswered live request becomes stale.
        ifid_valid_q <= 1'b0;
        ifid_inst_q  <= NOP_INST;
        buf_pc_q     <= '0;
        buf_inst_q   <= '0;
        case (state_q)
          S_FETCH: state_q <= imem_ack ? S_FETCH : S_DROP;
          S_HOLD:  state_q <= S_FETCH;
          S_DROP:  state_q <= imem_ack ? S_FETCH : S_DROP;
          default: state_q <= S_FETCH;
        endcase
      end else begin
        case (state_q)
          S_FETCH: begin
            if (imem_ack) begin
              if (stall_id) begin
                buf_pc_q   <= pc_if;
                buf_inst_q <= imem_rdata;
                state_q    <= S_HOLD;
              end else begin
                ifid_valid_q <= 1'b1;
                ifid_pc_q    <= pc_if;
                ifid_inst_q  <= imem_rdata;
              end
            end
          end
          S_HOLD: begin
            if (!stall_id) begin
              ifid_valid_q <= 1'b1;
              ifid_pc_q    <= buf_pc_q;
              ifid_inst_q  <= buf_inst_q;
              buf_pc_q     <= '0;
              buf_inst_q   <= '0;
              state_q      <= S_FETCH;
            end
          end
          S_DROP: begin
            // Wrong-path response is dropped; the new PC is fetched next cycle.
            if (imem_ack) begin
              state_q <= S_FETCH;
            end
          end
          default: state_q <= S_FETCH;
        endcase
      end
    end
  end

  assign ifid_valid = ifid_valid_q;
  assign ifid_pc    = ifid_pc_q;
  assign ifid_inst  = ifid_inst_q;
  assign imem_err   = imem_err_q;

endmodule

// File: tb/tb_pipeline_fetch_ctrl.sv
// Bench for pipeline_fetch_ctrl: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_pipeline_fetch_ctrl;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          MAXW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        stall_id;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_en;
  logic        pc_sel;
  logic [31:0] pc_target;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        imem_err;

  int checks = 0;
  int errors = 0;

  pipeline_fetch_ctrl #(.NOP_INST(NOP), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .pc_if(pc_if),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall_id(stall_id), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc_en(pc_en), .pc_sel(pc_sel), .pc_target(pc_target),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst),
    .imem_err(imem_err)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: mem[a] = a | 0xA000.
  assign imem_rdata = imem_addr | 32'h0000_A000;

  // PC register of the IF stage.
  always @(posedge clk) begin
    if (rst)        pc_if <= 32'h0;
    else if (pc_en) pc_if <= pc_sel ? pc_target : pc_if + 32'd4;
  end

  // Reference model: what the sequencer is holding, in transaction terms.
  bit          m_buf_full;
  logic [31:0] m_buf_pc, m_buf_inst;
  bit          m_stale;
  logic [31:0] m_stale_addr;
  bit          m_ifid_valid;
  logic [31:0] m_ifid_pc, m_ifid_inst;
  int          m_miss;
  bit          m_err;
  logic        exp_req, exp_pc_en, exp_pc_sel;
  logic [31:0] exp_addr;

  // Apply inputs at posedge+1, move to the falling edge and form expectations.
  task automatic drive(input logic r, input logic rv, input logic [31:0] rt,
                       input logic st, input logic ak);
    rst = r; redirect_valid = rv; redirect_target = rt; stall_id = st; imem_ack = ak;
    #4;
    exp_req    = !r && !m_buf_full;
    exp_addr   = m_stale ? m_stale_addr : pc_if;
    exp_pc_en  = !r && (rv || (exp_req && !m_stale && ak));
    exp_pc_sel = rv;
  endtask

  // Commit the model for this cycle, then cross the rising edge.
  task automatic advance();
    logic [31:0] a;
    a = exp_addr;
    if (rst) begin
      m_buf_full = 0; m_buf_pc = 0; m_buf_inst = 0; m_stale = 0; m_stale_addr = 0;
      m_ifid_valid = 0; m_ifid_pc = 0; m_ifid_inst = NOP; m_miss = 0; m_err = 0;
    end else begin
      if (exp_req) begin
        if (imem_ack) m_miss = 0;
        else begin
          if (m_miss < 1000) m_miss++;
          if (m_miss >= MAXW - 1) m_err = 1;
        end
      end
      if (redirect_valid) begin
        m_ifid_valid = 0; m_ifid_inst = NOP; m_buf_full = 0;
        m_stale = exp_req && !imem_ack;
        m_stale_addr = a;
      end else if (m_buf_full) begin
        if (!stall_id) begin
          m_ifid_valid = 1; m_ifid_pc = m_buf_pc; m_ifid_inst = m_buf_inst; m_buf_full = 0;
        end
      end else if (m_stale) begin
        if (imem_ack) m_stale = 0;
      end else if (imem_ack) begin
        if (stall_id) begin
          m_buf_full = 1; m_buf_pc = a; m_buf_inst = a | 32'h0000_A000;
        end else begin
          m_ifid_valid = 1; m_ifid_pc = a; m_ifid_inst = a | 32'h0000_A000;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    drive(1, 0, 0, 0, 0); advance();
    drive(1, 0, 0, 0, 0); advance();
  endtask

  task automatic test_reset();
    drive(1, 1, 32'h40, 0, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b exp 0", imem_req); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_pc_en: got %b exp 0", pc_en); end
    advance();
    drive(1, 0, 0, 0, 0); advance();
    drive(0, 0, 0, 0, 0);
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_ifid_valid: got %b exp 0", ifid_valid); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL rst_ifid_pc: got %h exp 0", ifid_pc); end
    checks++; if (ifid_inst !== NOP) begin errors++; $display("FAIL rst_ifid_inst: got %h exp %h", ifid_inst, NOP); end
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", imem_err); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rst_first_req: got %b/%h exp 1/0", imem_req, imem_addr); end
    checks++; if (pc_en !== 1'b0) begin errors++; $display("FAIL rst_noack_pc_en: got %b exp 0", pc_en); end
    advance();
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 1);
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL stream_addr%0d: got %h exp %h", i, imem_addr, 32'(4 * i)); end
      advance();
      checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'(4 * i)) begin errors++; $display("FAIL stream_pc%0d: got %b/%h exp 1/%h", i, ifid_valid, ifid_pc, 32'(4 * i)); end
      checks++; if (ifid_inst !== (32'(4 * i) | 32'hA000)) begin errors++; $display("FAIL stream_inst%0d: got %h exp %h", i, ifid_inst, 32'(4 * i) | 32'hA000); end
    end
  endtask

  task automatic test_latency();
    apply_reset();
    drive(0, 0, 0, 0, 1); advance();
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, k == 2);
      checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL lat_addr%0d: got %h exp 4", k, imem_addr); end
      checks++; if (pc_en !== (k == 2)) begin errors++; $display("FAIL lat_pc_en%0d: got %b exp %b", k, pc_en, k == 2); end
      advance();
    end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin errors++; $display("FAIL lat_ifid: got %b/%h exp 1/4", ifid_valid, ifid_pc); end
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL lat_err: got %b exp 0", imem_err); end
  endtask

  task automatic test_stall();
    apply_reset();
    drive(0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 0, 1); advance();
    drive(0, 0, 0, 1, 1);
    checks++; if (imem_addr !== 32'h8 || pc_en !== 1'b1 || pc_sel !== 1'b0) begin errors++; $display("FAIL stall_ack: got %h/%b/%b exp 8/1/0", imem_addr, pc_en, pc_sel); end
    advance();
    checks++; if (ifid_pc !== 32'h4) begin errors++; $display("FAIL stall_keep1: got %h exp 4", ifid_pc); end
    drive(0, 0, 0, 1, 0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_hold_req: got %b exp 0", imem_req); end
    advance();
    checks++; if (ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin errors++; $display("FAIL stall_keep2: got %b/%h exp 1/4", ifid_valid, ifid_pc); end
    drive(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_rel_req: got %b exp 0", imem_req); end
    advance();
    checks++; if (ifid_pc !== 32'h8 || ifid_inst !== 32'hA008) begin errors++; $display("FAIL stall_rel_ifid: got %h/%h exp 8/a008", ifid_pc, ifid_inst); end
    drive(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin errors++; $display("FAIL stall_next_req: got %b/%h exp 1/c", imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_redirect_pending();
    apply_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 1); advance(); end
    drive(0, 1, 32'h100, 0, 0);
    checks++; if (pc_en !== 1'b1 || pc_sel !== 1'b1 || pc_target !== 32'h100) begin errors++; $display("FAIL rdp_pc: got %b/%b/%h exp 1/1/100", pc_en, pc_sel, pc_target); end
    checks++; if (imem_addr !== 32'h10) begin errors++; $display("FAIL rdp_addr0: got %h exp 10", imem_addr); end
    advance();
    checks++; if (ifid_valid !== 1'b0 || ifid_inst !== NOP) begin errors++; $display("FAIL rdp_flush: got %b/%h exp 0/%h", ifid_valid, ifid_inst, NOP); end
    drive(0, 0, 0, 0, 0);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10 || pc_en !== 1'b0) begin errors++; $display("FAIL rdp_wait: got %b/%h/%b exp 1/10/0", imem_req, imem_addr, pc_en); end
    advance();
    drive(0, 0, 0, 0, 1);
    checks++; if (imem_addr !== 32'h10 || pc_en !== 1'b0) begin errors++; $display("FAIL rdp_drop: got %h/%b exp 10/0", imem_addr, pc_en); end
    advance();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rdp_discard: got %b exp 0", ifid_valid); end
    drive(0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rdp_new_req: got %b/%h exp 1/100", imem_req, imem_addr); end
    advance();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100 || ifid_inst !== 32'hA100) begin errors++; $display("FAIL rdp_new_ifid: got %b/%h/%h exp 1/100/a100", ifid_valid, ifid_pc, ifid_inst); end
  endtask

  task automatic test_redirect_same_cycle();
    apply_reset();
    for (int i = 0; i < 5; i++) begin drive(0, 0, 0, 0, 1); advance(); end
    drive(0, 1, 32'h200, 0, 1);
    checks++; if (imem_addr !== 32'h14 || pc_en !== 1'b1 || pc_sel !== 1'b1) begin errors++; $display("FAIL rds_cycle: got %h/%b/%b exp 14/1/1", imem_addr, pc_en, pc_sel); end
    advance();
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rds_discard: got %b exp 0", ifid_valid); end
    drive(0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rds_new_req: got %b/%h exp 1/200", imem_req, imem_addr); end
    advance();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200) begin errors++; $display("FAIL rds_new_ifid: got %b/%h exp 1/200", ifid_valid, ifid_pc); end
  endtask

  task automatic test_timeout();
    apply_reset();
    drive(0, 0, 0, 0, 1); advance();
    for (int k = 1; k <= MAXW; k++) begin
      drive(0, 0, 0, 0, 0);
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL to_req%0d: got %b/%h exp 1/4", k, imem_req, imem_addr); end
      checks++; if (imem_err !== (k >= MAXW)) begin errors++; $display("FAIL to_err%0d: got %b exp %b", k, imem_err, k >= MAXW); end
      advance();
    end
    drive(0, 0, 0, 0, 1);
    checks++; if (imem_req !== 1'b1 || pc_en !== 1'b1) begin errors++; $display("FAIL to_late_ack: got %b/%b exp 1/1", imem_req, pc_en); end
    advance();
    checks++; if (ifid_pc !== 32'h4 || ifid_valid !== 1'b1 || imem_err !== 1'b1) begin errors++; $display("FAIL to_done: got %h/%b/%b exp 4/1/1", ifid_pc, ifid_valid, imem_err); end
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 1); advance(); end
    checks++; if (imem_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b exp 1", imem_err); end
    apply_reset();
    drive(0, 0, 0, 0, 0);
    checks++; if (imem_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b exp 0", imem_err); end
    advance();
  endtask

  task automatic test_random();
    logic r, rv, st, ak;
    logic [31:0] rt;
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      rv = ($urandom_range(0, 9) == 0);
      rt = 32'($urandom_range(0, 1023)) << 2;
      st = ($urandom_range(0, 2) == 0);
      ak = (((n / 250) % 4) == 3) ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 1) == 0);
      drive(r, rv, rt, st, ak);
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req c%0d: got %b exp %b", n, imem_req, exp_req); end
      if (exp_req) begin
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL rnd_addr c%0d: got %h exp %h", n, imem_addr, exp_addr); end
      end
      checks++; if (pc_en !== exp_pc_en) begin errors++; $display("FAIL rnd_pc_en c%0d: got %b exp %b", n, pc_en, exp_pc_en); end
      if (exp_pc_en) begin
        checks++; if (pc_sel !== exp_pc_sel) begin errors++; $display("FAIL rnd_pc_sel c%0d: got %b exp %b", n, pc_sel, exp_pc_sel); end
        if (exp_pc_sel) begin
          checks++; if (pc_target !== rt) begin errors++; $display("FAIL rnd_target c%0d: got %h exp %h", n, pc_target, rt); end
        end
      end
      checks++; if (ifid_valid !== m_ifid_valid) begin errors++; $display("FAIL rnd_valid c%0d: got %b exp %b", n, ifid_valid, m_ifid_valid); end
      if (m_ifid_valid) begin
        checks++; if (ifid_pc !== m_ifid_pc) begin errors++; $display("FAIL rnd_ifid_pc c%0d: got %h exp %h", n, ifid_pc, m_ifid_pc); end
      end
      checks++; if (ifid_inst !== m_ifid_inst) begin errors++; $display("FAIL rnd_inst c%0d: got %h exp %h", n, ifid_inst, m_ifid_inst); end
      checks++; if (imem_err !== m_err) begin errors++; $display("FAIL rnd_err c%0d: got %b exp %b", n, imem_err, m_err); end
      advance();
    end
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_target = '0; stall_id = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_latency();
    test_stall();
    test_redirect_pending();
    test_redirect_same_cycle();
    test_timeout();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
